pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
// - Central stall/flush/freeze sequencer for the 5-stage ARM-subset pipeline (IF/ID/EXE/MEM/WB).
// - Detects RAW hazards for the instruction in ID and drives the ID-stage `hazard` input.
// - Freezes the whole pipeline during multi-cycle SRAM accesses and flushes younger stages on taken branches.
// - Keeps saturating stall/flush performance counters and a memory-timeout error flag.
// PARAMETERS
// - TIMEOUT_CYCLES  64  max MEM_WAIT cycles before mem_err is raised and the access is abandoned
// - CNT_W           16  width of the stall_count and flush_count performance counters
// PORTS
// - clk             in   1      pipeline clock, rising edge
// - rst             in   1      synchronous, active-high reset
// - fwd_en          in   1      1 = forwarding unit active (only load-use stalls); 0 = stall on any RAW
// - id_src1         in   4      ID src1 (Rn)
// - id_src2         in   4      ID src2 (Rm, or Rd for stores)
// - id_two_src      in   1      ID instruction reads src2
// - exe_dest        in   4      EXE-stage destination register
// - exe_wb_en       in   1      EXE instruction writes back
// - exe_mem_r_en    in   1      EXE instruction is a load
// - mem_dest        in   4      MEM-stage destination register
// - mem_wb_en       in   1      MEM instruction writes back
// - mem_r_en        in   1      MEM stage requests an SRAM read
// - mem_w_en        in   1      MEM stage requests an SRAM write
// - sram_ready      in   1      SRAM access complete (1-cycle pulse)
// - exe_branch      in   1      EXE instruction is a taken branch (post condition check)
// - hazard          out  1      to ID stage: insert bubble, hold PC and IF/ID
// - freeze          out  1      hold every pipeline register (SRAM wait)
// - flush           out  1      clear IF/ID and ID/EXE registers
// - sram_req        out  1      one-cycle start pulse to the SRAM controller
// - mem_err         out  1      sticky timeout flag; cleared only by rst
// - stall_count     out  CNT_W  cycles with hazard or freeze asserted, saturating
// - flush_count     out  CNT_W  cycles with flush asserted, saturating
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): state=RUN; all outputs 0; counters 0; mem_err 0; wait counter 0.
// - FSM states: RUN, MEM_REQ, MEM_WAIT.
//   - RUN: (mem_r_en|mem_w_en) & ~mem_err -> MEM_REQ.
//   - MEM_REQ: sram_req=1 for exactly this cycle -> MEM_WAIT.
//   - MEM_WAIT: sram_ready -> RUN; wait count reaches TIMEOUT_CYCLES-1 without ready -> set mem_err, -> RUN.
//   - sram_ready in RUN or MEM_REQ is ignored.
// - freeze = (state!=RUN) | (state==RUN & (mem_r_en|mem_w_en) & ~mem_err). Combinational, same cycle as the request.
//   - Deasserts in the cycle after sram_ready is sampled.
// - Once mem_err is set, memory requests are no longer frozen (treated as 0-latency) so the pipeline drains.
// - RAW detection (combinational, ID vs EXE and MEM):
//   - hit_x = exe_wb_en & (id_src1==exe_dest | id_two_src & id_src2==exe_dest)
//   - hit_m = the same against mem_dest/mem_wb_en.
//   - fwd_en=0: raw = hit_x | hit_m.  fwd_en=1: raw = hit_x & exe_mem_r_en (load-use only).
// - Priority: freeze > flush > hazard.
//   - flush = exe_branch & ~freeze.
//   - hazard = raw & ~freeze & ~exe_branch. A branch flushes ID, so no bubble is needed.
// - A branch in EXE during freeze is held. flush fires in the first unfrozen cycle; the EXE register must still hold it.
// - Latency: hazard and flush are 0-cycle combinational. Counters update at the next posedge. All registered outputs change only on posedge clk.
// - Counters: +1 per qualifying cycle and saturate at all-ones (no wrap).
//   - stall_count qualifies on hazard|freeze; in MEM_REQ/MEM_WAIT it counts via freeze.
// - rst mid-access: FSM returns to RUN immediately and sram_req is not reissued. The SRAM controller is reset by the same rst.
// STRUCTURE
// - Shared package arm_pipe_pkg: state enum (RUN/MEM_REQ/MEM_WAIT) and REG_W=4 register-index width.
// - One sub-module: sat_counter #(W) (en, clr, count), instanced twice for the performance counters.
// - RAW comparators, FSM and wait counter stay in this module.
// TESTING
// - RAW, no forwarding: fwd_en=0, exe_dest=3 exe_wb_en=1, id_src1=3 -> hazard=1, stall_count +1. id_src1=4 -> hazard=0.
// - Load-use: fwd_en=1, exe_mem_r_en=1 exe_dest=5, id_two_src=1 id_src2=5 -> hazard=1. Same with exe_mem_r_en=0 -> hazard=0.
// - SRAM read, sram_ready after 4 cycles:
//   - freeze=1 from the request cycle through the ready cycle (6 cycles total).
//   - sram_req pulses once; stall_count=6.
// - Branch during freeze: exe_branch=1 while in MEM_WAIT -> flush=0. On the cycle after sram_ready -> flush=1 for one cycle, flush_count=1.
// - Timeout: TIMEOUT_CYCLES=8, never ready -> mem_err=1 after 8 MEM_WAIT cycles, freeze drops, mem_err sticks until rst.
// - Saturation and reset: CNT_W=4, 20 hazard cycles -> stall_count=15. rst=1 during MEM_WAIT -> next cycle freeze=0, counters=0.

Source files
------------

// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions: register-index width and the memory-access sequencer states.
package arm_pipe_pkg;
  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // True when an instruction reading src1 (and src2 if two_src) depends on dest.
  function automatic logic reads_reg(input logic [REG_W-1:0] src1,
                                     input logic [REG_W-1:0] src2,
                                     input logic             two_src,
                                     input logic [REG_W-1:0] dest);
    return (src1 == dest) | (two_src & (src2 == dest));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: RAW bubbles, SRAM freeze with
// timeout, branch flush, and saturating stall/flush counters.
module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  input  logic             exe_branch,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             sram_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_acc, hit_x, hit_m, raw, freeze_c;

  assign mem_acc = (mem_r_en | mem_w_en) & ~mem_err;
  assign hit_x   = exe_wb_en & reads_reg(id_src1, id_src2, id_two_src, exe_dest);
  assign hit_m   = mem_wb_en & reads_reg(id_src1, id_src2, id_two_src, mem_dest);
  assign raw     = fwd_en ? (hit_x & exe_mem_r_en) : (hit_x | hit_m);

  // Freeze covers the request cycle itself so the MEM instruction never advances early.
  assign freeze_c = (state != RUN) | mem_acc;
  assign freeze   = ~rst & freeze_c;
  assign flush    = ~rst & exe_branch & ~freeze_c;
  assign hazard   = ~rst & raw & ~freeze_c & ~exe_branch;
  assign sram_req = ~rst & (state == MEM_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN:      if (mem_acc) state <= MEM_REQ;
        MEM_REQ: begin
          state    <= MEM_WAIT;
          wait_cnt <= '0;
        end
        MEM_WAIT: begin
          if (sram_ready)
            state <= RUN;
          else if (wait_cnt == WAIT_LAST) begin
            // Abandon the access; later requests pass through unfrozen so the pipe drains.
            mem_err <= 1'b1;
            state   <= RUN;
          end else
            wait_cnt <= wait_cnt + 1'b1;
        end
        default:  state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (hazard | freeze),
    .clr   (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .clr   (1'b0),
    .count (flush_count)
  );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scenarios plus randomized traffic, compared every cycle against a
// cycle-count reference model of the hazard/freeze/flush rules.
module tb_pipeline_hazard_controller;
  localparam int TO    = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fwd_en = 0, id_two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0;
  logic          mem_wb_en = 0, mem_r_en = 0, mem_w_en = 0, sram_ready = 0, exe_branch = 0;
  logic [3:0]    id_src1 = 0, id_src2 = 0, exe_dest = 0, mem_dest = 0;
  logic          hazard, freeze, flush, sram_req, mem_err;
  logic [CW-1:0] stall_count, flush_count;

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
    .exe_branch(exe_branch),
    .hazard(hazard), .freeze(freeze), .flush(flush), .sram_req(sram_req),
    .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_sreq = 0;
  // Reference model: access in flight, cycles since the request was accepted, sticky error.
  bit m_busy = 0, m_err = 0;
  int m_age = 0, m_stall = 0, m_flush = 0;
  bit obs_hazard, obs_freeze, obs_flush, obs_sreq;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [3:0] r);
    return (id_src1 == r) || (id_two_src && id_src2 == r);
  endfunction

  task automatic cyc();
    bit mreq, ef, es, efl, eh, hx, hm, raw;
    @(negedge clk);
    mreq = (mem_r_en || mem_w_en) && !m_err;
    ef   = !rst && (m_busy || mreq);
    es   = !rst && m_busy && (m_age == 0);
    efl  = !rst && exe_branch && !ef;
    hx   = exe_wb_en && reads(exe_dest);
    hm   = mem_wb_en && reads(mem_dest);
    raw  = fwd_en ? (hx && exe_mem_r_en) : (hx || hm);
    eh   = !rst && raw && !ef && !exe_branch;
    obs_hazard = hazard; obs_freeze = freeze; obs_flush = flush; obs_sreq = sram_req;
    if (sram_req) n_sreq++;
    chk("hazard", int'(hazard), int'(eh));
    chk("freeze", int'(freeze), int'(ef));
    chk("flush", int'(flush), int'(efl));
    chk("sram_req", int'(sram_req), int'(es));
    chk("mem_err", int'(mem_err), int'(m_err));
    chk("stall_count", int'(stall_count), m_stall);
    chk("flush_count", int'(flush_count), m_flush);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_err = 0; m_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      if ((eh || ef) && m_stall < CMAX) m_stall++;
      if (efl && m_flush < CMAX) m_flush++;
      if (!m_busy) begin
        if (mreq) begin m_busy = 1; m_age = 0; end
      end else if (m_age == 0) m_age = 1;
      else if (sram_ready) m_busy = 0;
      else if (m_age == TO) begin m_err = 1; m_busy = 0; end
      else m_age++;
    end
    #1;
  endtask

  task automatic clear_in();
    fwd_en = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    mem_r_en = 0; mem_w_en = 0; sram_ready = 0; exe_branch = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
  endtask

  task automatic do_reset();
    clear_in(); rst = 1; cyc(); rst = 0;
  endtask

  initial begin
    rst = 1; clear_in();
    #1; cyc(); cyc(); rst = 0;
    chk("rst_stall", int'(stall_count), 0);
    chk("rst_freeze", int'(obs_freeze), 0);

    // RAW without forwarding
    exe_dest = 3; exe_wb_en = 1; id_src1 = 3; cyc();
    chk("raw_nofwd_hz", int'(obs_hazard), 1);
    chk("raw_nofwd_cnt", int'(stall_count), 1);
    id_src1 = 4; cyc();
    chk("raw_nofwd_clear", int'(obs_hazard), 0);

    // Load-use with forwarding
    clear_in(); fwd_en = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5;
    id_two_src = 1; id_src2 = 5; cyc();
    chk("load_use_hz", int'(obs_hazard), 1);
    exe_mem_r_en = 0; cyc();
    chk("fwd_no_hz", int'(obs_hazard), 0);

    // SRAM read, ready on the 4th wait cycle, branch held in EXE meanwhile
    do_reset(); n_sreq = 0;
    mem_r_en = 1; cyc(); cyc();
    exe_branch = 1;
    cyc(); cyc(); cyc();
    chk("branch_frozen", int'(obs_flush), 0);
    sram_ready = 1; cyc();
    chk("ready_cycle_frz", int'(obs_freeze), 1);
    sram_ready = 0; mem_r_en = 0; cyc();
    chk("post_ready_frz", int'(obs_freeze), 0);
    chk("post_ready_flush", int'(obs_flush), 1);
    chk("sram_stall_cnt", int'(stall_count), 6);
    chk("sram_req_pulses", n_sreq, 1);
    exe_branch = 0; cyc();
    chk("flush_cnt", int'(flush_count), 1);

    // Timeout: never ready
    do_reset();
    mem_w_en = 1;
    for (int i = 0; i < 2 + TO; i++) cyc();
    chk("timeout_err", int'(mem_err), 1);
    cyc();
    chk("timeout_frz_drop", int'(obs_freeze), 0);
    for (int i = 0; i < 3; i++) cyc();
    chk("err_sticky", int'(mem_err), 1);
    do_reset();
    chk("err_cleared", int'(mem_err), 0);

    // Saturation
    exe_dest = 3; exe_wb_en = 1; id_src1 = 3;
    for (int i = 0; i < 20; i++) cyc();
    chk("stall_sat", int'(stall_count), CMAX);

    // Reset in the middle of an access
    clear_in(); mem_r_en = 1; cyc(); cyc(); cyc();
    mem_r_en = 0; rst = 1; cyc(); rst = 0; cyc();
    chk("rst_mid_frz", int'(obs_freeze), 0);
    chk("rst_mid_cnt", int'(stall_count), 0);
    chk("rst_mid_req", int'(obs_sreq), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(63) == 0);
      fwd_en       = $urandom_range(1);
      id_src1      = 4'($urandom_range(7));
      id_src2      = 4'($urandom_range(7));
      id_two_src   = $urandom_range(1);
      exe_dest     = 4'($urandom_range(7));
      exe_wb_en    = $urandom_range(1);
      exe_mem_r_en = $urandom_range(1);
      mem_dest     = 4'($urandom_range(7));
      mem_wb_en    = $urandom_range(1);
      mem_r_en     = ($urandom_range(5) == 0);
      mem_w_en     = ($urandom_range(7) == 0);
      sram_ready   = ($urandom_range(3) == 0);
      exe_branch   = ($urandom_range(5) == 0);
      cyc();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
